seg_scan_reader: RTL



---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_pat_decode.sv | 34 +++
 rtl/seg_scan_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - legal segment patterns, FSM states and one-hot helper for seg_scan_reader
package seg_pkg;

   // Segment order is {a,b,c,d,e,f,g}, active high.
   localparam logic [6:0] PAT_0 = 7'h7E;
   localparam logic [6:0] PAT_1 = 7'h30;
   localparam logic [6:0] PAT_2 = 7'h6D;
   localparam logic [6:0] PAT_3 = 7'h79;
   localparam logic [6:0] PAT_4 = 7'h33;
   localparam logic [6:0] PAT_5 = 7'h5B;
   localparam logic [6:0] PAT_6 = 7'h5F;
   localparam logic [6:0] PAT_7 = 7'h70;
   localparam logic [6:0] PAT_8 = 7'h7F;
   localparam logic [6:0] PAT_9 = 7'h7B;
   localparam logic [6:0] PAT_A = 7'h77;
   localparam logic [6:0] PAT_B = 7'h1F;
   localparam logic [6:0] PAT_C = 7'h4E;
   localparam logic [6:0] PAT_D = 7'h3D;
   localparam logic [6:0] PAT_E = 7'h4F;
   localparam logic [6:0] PAT_F = 7'h47;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   function automatic logic is_onehot(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/seg_pat_decode.sv
// rtl/seg_pat_decode.sv - combinational 7-segment pattern to hex nibble decoder
module seg_pat_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic [3:0] nibble
);

   always_comb begin
      valid  = 1'b1;
      nibble = 4'h0;
      case (seg)
         PAT_0:   nibble = 4'h0;
         PAT_1:   nibble = 4'h1;
         PAT_2:   nibble = 4'h2;
         PAT_3:   nibble = 4'h3;
         PAT_4:   nibble = 4'h4;
         PAT_5:   nibble = 4'h5;
         PAT_6:   nibble = 4'h6;
         PAT_7:   nibble = 4'h7;
         PAT_8:   nibble = 4'h8;
         PAT_9:   nibble = 4'h9;
         PAT_A:   nibble = 4'hA;
         PAT_B:   nibble = 4'hB;
         PAT_C:   nibble = 4'hC;
         PAT_D:   nibble = 4'hD;
         PAT_E:   nibble = 4'hE;
         PAT_F:   nibble = 4'hF;
         default: valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_reader.sv
// rtl/seg_scan_reader.sv - scanned 7-segment display reader with settle/stability filtering
// Optional SEG_READER_ERRCNT_EN adds a saturating err_cnt of bad_pat pulses.
module seg_scan_reader
   import seg_pkg::*;
#(
   parameter int NDIG         = 4,
   parameter int SETTLE_CYC   = 4,
   parameter int STABLE_SCANS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NDIG-1:0]   dig_sel,
   input  logic [6:0]        seg_in,
   output logic [4*NDIG-1:0] out_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              bad_pat
`ifdef SEG_READER_ERRCNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int CW = $clog2(SETTLE_CYC + 1);
   localparam int MW = $clog2(STABLE_SCANS + 1);
   localparam logic [CW:0]   SETTLE_V = (CW + 1)'(SETTLE_CYC);
   localparam logic [MW-1:0] STAB_V   = MW'(STABLE_SCANS);

   state_t              state;
   logic [NDIG-1:0]     smp_sel;
   logic [6:0]          smp_seg;
   logic [CW-1:0]       cnt;
   logic [4*NDIG-1:0]   cand;
   logic [MW-1:0]       match [NDIG];
   logic [4*NDIG-1:0]   committed;
   logic [NDIG-1:0]     seen;
   logic [4*NDIG-1:0]   last_val;
   logic                last_ok;

   logic                sel_ok;
   logic                same;
   logic [CW:0]         cnt_inc;
   logic                capture;
   logic                dec_valid;
   logic [3:0]          dec_nib;
   logic [3:0]          cur_cand;
   logic [MW-1:0]       cur_match;
   logic [MW-1:0]       new_match;
   logic                emit_chk;
   logic                emit_load;

   assign sel_ok    = is_onehot(8'(dig_sel));
   assign same      = (dig_sel == smp_sel) && (seg_in == smp_seg);
   assign cnt_inc   = {1'b0, cnt} + 1'b1;
   assign capture   = (state == SETTLE) && sel_ok && same && (cnt_inc >= SETTLE_V);
   assign emit_chk  = (&seen) && (!out_valid || out_ready);
   assign emit_load = emit_chk && (!last_ok || (committed != last_val));

   seg_pat_decode u_dec (
      .seg    (smp_seg),
      .valid  (dec_valid),
      .nibble (dec_nib)
   );

   // Candidate/match state of the digit currently being sampled.
   always_comb begin
      cur_cand  = 4'h0;
      cur_match = '0;
      for (int d = 0; d < NDIG; d++) begin
         if (smp_sel[d]) begin
            cur_cand  = cand[4*d +: 4];
            cur_match = match[d];
         end
      end
      if (dec_nib == cur_cand)
         new_match = (cur_match == STAB_V) ? STAB_V : cur_match + 1'b1;
      else
         new_match = MW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         smp_sel   <= '0;
         smp_seg   <= '0;
         cnt       <= '0;
         cand      <= '0;
         committed <= '0;
         seen      <= '0;
         last_val  <= '0;
         last_ok   <= 1'b0;
         out_value <= '0;
         out_valid <= 1'b0;
         bad_pat   <= 1'b0;
         for (int d = 0; d < NDIG; d++)
            match[d] <= '0;
      end else begin
         bad_pat <= capture && !dec_valid;

         case (state)
            IDLE: begin
               if (sel_ok) begin
                  smp_sel <= dig_sel;
                  smp_seg <= seg_in;
                  cnt     <= CW'(1);
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (!sel_ok) begin
                  state <= IDLE;
               end else if (!same) begin
                  smp_sel <= dig_sel;
                  smp_seg <= seg_in;
                  cnt     <= CW'(1);
               end else begin
                  cnt <= cnt_inc[CW-1:0];
                  if (capture)
                     state <= HOLD;
               end
            end
            HOLD: begin
               if (dig_sel != smp_sel)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // A commit landing in the same cycle as an emit check belongs to the next frame.
         if (emit_chk)
            seen <= '0;

         if (emit_load) begin
            out_value <= committed;
            last_val  <= committed;
            last_ok   <= 1'b1;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         for (int d = 0; d < NDIG; d++) begin
            if (capture && smp_sel[d]) begin
               if (dec_valid) begin
                  cand[4*d +: 4] <= dec_nib;
                  match[d]       <= new_match;
                  if (new_match == STAB_V) begin
                     committed[4*d +: 4] <= dec_nib;
                     seen[d]             <= 1'b1;
                  end
               end else begin
                  match[d] <= '0;
               end
            end
         end
      end
   end

`ifdef SEG_READER_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= 8'd0;
      else if (bad_pat && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule
